// File: rtl/fft_ctrl_if.sv
// Control/address bundle between the FFT sequencer and the RAM, ROM
// and butterfly datapath.
interface fft_ctrl_if #(
    parameter int N = 9
);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [N-1:0]         add_a;
    logic [N-1:0]         add_b;
    logic [N-2:0]         tw_add;
    logic [$clog2(N)-1:0] stage;
    logic                 bf_load;
    logic                 we;

    modport master (
        input  start,
        output busy, done, add_a, add_b, tw_add,
        output stage, bf_load, we
    );

    modport slave (
        output start,
        input  busy, done, add_a, add_b, tw_add,
        input  stage, bf_load, we
    );
endinterface

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: walks stages and butterflies,
// producing RAM/twiddle addresses and load/write strobes.
module fft_ctrl #(
    parameter int N      = 9,
    parameter int BF_LAT = 3
) (
    input  logic      clk,
    input  logic      reset,
    fft_ctrl_if.master bus
);

    localparam int SW = $clog2(N);
    localparam int BW = N - 1;
    localparam int CW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    localparam logic [BW-1:0] B_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(N - 1);
    localparam logic [CW-1:0] C_LAST = CW'(BF_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CALC,
        WRITE,
        FIN
    } state_t;

    state_t        state, state_n;
    logic [SW-1:0] s, s_n;
    logic [BW-1:0] b, b_n;
    logic [CW-1:0] cnt, cnt_n;

    logic [BW-1:0] mask;
    logic [N-1:0]  a_n, ab_n;
    logic [BW-1:0] tw_n;
    logic [N-1:0]  a_q, ab_q;
    logic [BW-1:0] tw_q;

    always_comb begin
        state_n = state;
        s_n     = s;
        b_n     = b;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = READ;
                    s_n     = '0;
                    b_n     = '0;
                end
            end
            READ: begin
                state_n = CALC;
                cnt_n   = '0;
            end
            CALC: begin
                if (cnt == C_LAST) begin
                    state_n = WRITE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WRITE: begin
                if (b != B_LAST) begin
                    state_n = READ;
                    b_n     = b + BW'(1);
                end else if (s != S_LAST) begin
                    state_n = READ;
                    b_n     = '0;
                    s_n     = s + SW'(1);
                end else begin
                    state_n = FIN;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Split b at bit s: upper part moves up one place to open the gap.
    always_comb begin
        mask = (BW'(1) << s_n) - BW'(1);
        a_n  = (N'(b_n & ~mask) << 1) | N'(b_n & mask);
        ab_n = a_n | (N'(1) << s_n);
        tw_n = (b_n & mask) << (BW - int'(s_n));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            s     <= '0;
            b     <= '0;
            cnt   <= '0;
            a_q   <= '0;
            ab_q  <= '0;
            tw_q  <= '0;
        end else begin
            state <= state_n;
            s     <= s_n;
            b     <= b_n;
            cnt   <= cnt_n;
            if (state_n == READ) begin
                a_q  <= a_n;
                ab_q <= ab_n;
                tw_q <= tw_n;
            end
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.bf_load = (state == READ);
    assign bus.we      = (state == WRITE);
    assign bus.done    = (state == FIN);
    assign bus.add_a   = a_q;
    assign bus.add_b   = ab_q;
    assign bus.tw_add  = tw_q;
    assign bus.stage   = s;

endmodule
